// File: rtl/regfile_64x32.sv
// ---------------------------------------------------------------------------
// regfile_64x32
//
// Architectural integer register file: DEPTH registers of WIDTH bits, two
// combinational read ports and one synchronous write port. Index ZERO_REG is
// hardwired to zero (XZR): writes to it are dropped and reads return 0.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset, clears every register
//   RegWrite       in   write enable, sampled at the rising edge
//   WriteRegister  in   [4:0] destination register index
//   WriteData      in   [WIDTH-1:0] write data (ALU result or load data)
//   ReadRegister1  in   [4:0] A operand index
//   ReadRegister2  in   [4:0] B operand index
//   ReadData1      out  [WIDTH-1:0] A operand, zero-cycle read
//   ReadData2      out  [WIDTH-1:0] B operand, zero-cycle read
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read port addressing the register being
//                      written this cycle returns WriteData combinationally.
//                      When undefined, same-cycle reads return the old value.
// ---------------------------------------------------------------------------
module regfile_64x32 #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_en;

    // Writes aimed at the zero register are discarded here, so its storage
    // never leaves the reset value.
    assign wr_en = RegWrite && (WriteRegister != ZERO_IDX);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (WriteRegister == 5'(i))) begin
                regs_d[i] = WriteData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding must not leak data while reset holds the array at zero.
    logic byp_en;
    assign byp_en = wr_en && rst_n;
`endif

    always_comb begin
        ReadData1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ReadRegister1 == 5'(i)) begin
                ReadData1 = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (byp_en && (ReadRegister1 == WriteRegister)) begin
            ReadData1 = WriteData;
        end
`endif
        // XZR wins over storage and forwarding alike.
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end
    end

    always_comb begin
        ReadData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ReadRegister2 == 5'(i)) begin
                ReadData2 = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (byp_en && (ReadRegister2 == WriteRegister)) begin
            ReadData2 = WriteData;
        end
`endif
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_64x32.sv
// ---------------------------------------------------------------------------
// tb_regfile_64x32
//
// Directed bench for regfile_64x32. The stimulus process drives one vector per
// clock cycle, starting 1 time unit after the rising edge, and pushes the
// read-port values it expects for that cycle into a queue. The monitor process
// pops one entry at each falling edge (mid-cycle, before the next write edge)
// and compares both read ports against it.
// ---------------------------------------------------------------------------
module tb_regfile_64x32;

    localparam int WIDTH = 64;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string            name;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             RegWrite = 1'b0;
    logic [4:0]       WriteRegister = '0;
    logic [WIDTH-1:0] WriteData = '0;
    logic [4:0]       ReadRegister1 = '0;
    logic [4:0]       ReadRegister2 = '0;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    regfile_64x32 #(.WIDTH(WIDTH), .DEPTH(32), .ZERO_REG(31)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    always #5 clk = ~clk;

    // Monitor: compare whatever the stimulus expected for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (ReadData1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s port1: got %h expected %h", e.name, ReadData1, e.e1);
                end
                n_cmp++;
                if (ReadData2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s port2: got %h expected %h", e.name, ReadData2, e.e2);
                end
            end
        end
    end

    // One clock cycle of stimulus; optionally queue the expected read data.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [WIDTH-1:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input bit chk,
                       input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                       input string nm);
        exp_t e;
        rst_n         = rst;
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        if (chk) begin
            e.name = nm;
            e.e1   = e1;
            e.e2   = e2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        int wait_cnt;

        @(posedge clk);
        #1;

        // Reset holds everything at zero and ignores a write.
        cyc(1'b0, 1'b1, 5'd6, 64'h66, 5'd6, 5'd0, 1'b1, '0, '0, "reset_initial");
        cyc(1'b0, 1'b0, 5'd0, '0, 5'd6, 5'd6, 1'b1, '0, '0, "reset_wr_ignored");

        // Release reset and write X1 in the same cycle: the write lands.
        cyc(1'b1, 1'b1, 5'd1, 64'h1, 5'd1, 5'd6, 1'b1, BYP ? 64'h1 : 64'h0, '0, "first_write_cycle");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd1, 5'd1, 1'b1, 64'h1, 64'h1, "first_write_after");

        // Write/read: X3 visible one edge later, neighbours untouched.
        cyc(1'b1, 1'b1, 5'd3, 64'h0123456789ABCDEF, 5'd2, 5'd4, 1'b1, '0, '0, "wr_x3_neighbours");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd3, 5'd3, 1'b1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, "rd_x3");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd2, 5'd4, 1'b1, '0, '0, "rd_x2_x4");

        // Zero register: write discarded, reads always zero (also same cycle).
        cyc(1'b1, 1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFF, 5'd31, 5'd31, 1'b1, '0, '0, "xzr_wr_cycle");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd31, 5'd31, 1'b1, '0, '0, "xzr_after");

        // Disabled write: X7 keeps 0x11.
        cyc(1'b1, 1'b1, 5'd7, 64'h11, 5'd0, 5'd0, 1'b0, '0, '0, "");
        cyc(1'b1, 1'b0, 5'd7, 64'h55, 5'd7, 5'd3, 1'b1, 64'h11, 64'h0123456789ABCDEF, "disabled_wr_cycle");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd7, 1'b1, 64'h11, 64'h11, "disabled_wr_after");

        // Same-cycle collision on X9.
        cyc(1'b1, 1'b1, 5'd9, 64'hAA, 5'd0, 5'd0, 1'b0, '0, '0, "");
        cyc(1'b1, 1'b1, 5'd9, 64'hBB, 5'd9, 5'd7, 1'b1, BYP ? 64'hBB : 64'hAA, 64'h11, "collision_cycle");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd9, 5'd9, 1'b1, 64'hBB, 64'hBB, "collision_after");

        // Reset asserted mid-cycle after X5=0xDEAD, with a write pending.
        cyc(1'b1, 1'b1, 5'd5, 64'hDEAD, 5'd0, 5'd0, 1'b0, '0, '0, "");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd5, 1'b1, 64'hDEAD, 64'hDEAD, "x5_written");
        cyc(1'b0, 1'b1, 5'd5, 64'hBEEF, 5'd5, 5'd9, 1'b1, '0, '0, "reset_mid_cycle");
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 5'(i), 64'hCAFE, 5'(i), 5'(31 - i), 1'b1, '0, '0, "reset_scan");
        end
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd9, 1'b1, '0, '0, "post_reset_x5_x9");

        // Exhaustive: register i holds i, XZR reads zero.
        for (int i = 0; i < 31; i++) begin
            cyc(1'b1, 1'b1, 5'(i), 64'(i), 5'd31, 5'd31, 1'b0, '0, '0, "");
        end
        for (int i = 0; i < 32; i++) begin
            v = (i == 31) ? 64'h0 : 64'(i);
            cyc(1'b1, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i), 1'b1,
                v, (i == 0) ? 64'h0 : 64'(31 - i), "exhaustive");
        end

        RegWrite = 1'b0;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
